// File: rtl/timing_loop_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timing_loop_pkg
// Desc     : Loop states, gain-set type and saturating helpers for the timing loop
// Revision : 1.0 - initial release
// ============================================================================
package timing_loop_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACQ   = 2'd1,
      ST_TRACK = 2'd2,
      ST_HOLD  = 2'd3
   } loop_state_t;

   typedef struct packed {
      logic [4:0] kp_sh;
      logic [4:0] ki_sh;
   } gain_set_t;

   // Symmetric saturation to +/-(2^(width-1)-1); callers size-cast the result.
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int width);
      logic signed [63:0] sum;
      logic signed [63:0] lim;
      logic signed [63:0] res;
      sum = a + b;
      lim = (64'sd1 <<< (width - 1)) - 64'sd1;
      if (sum > lim)
         res = lim;
      else if (sum < -lim)
         res = -lim;
      else
         res = sum;
      return res;
   endfunction

   // |x| with the most negative code folded onto the largest positive one.
   function automatic logic signed [63:0] abs_sat(input logic signed [63:0] x,
                                                  input int width);
      logic signed [63:0] lim;
      logic signed [63:0] res;
      lim = (64'sd1 <<< (width - 1)) - 64'sd1;
      if (x < -lim)
         res = lim;
      else if (x < 0)
         res = -x;
      else
         res = x;
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/timing_loop_ctrl_pi_core.sv
`default_nettype none
// ============================================================================
// Module   : loop_pi_core
// Desc     : Two-stage PI datapath: error register, then integrator and output
// Revision : 1.0 - initial release
// ============================================================================
module loop_pi_core
   import timing_loop_pkg::*;
#(
   parameter int ERR_W  = 16,
   parameter int ACC_W  = 24,
   parameter int CTRL_W = 18
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ERR_W-1:0]  err,
   input  logic              val,
   input  gain_set_t         gains,
   input  logic              hold,
   input  logic              clear,
   output logic [CTRL_W-1:0] ctrl,
   output logic              ctrl_val
);

   logic signed [ERR_W-1:0]  r_err1;
   logic                     r_val1;
   gain_set_t                r_gain1;
   logic                     r_hold_d;
   logic signed [ACC_W-1:0]  r_integ;
   logic signed [CTRL_W-1:0] r_ctrl;
   logic                     r_ctrl_val;

   logic signed [63:0]       w_p;
   logic signed [63:0]       w_i_inc;
   logic signed [ACC_W-1:0]  w_integ_nx;
   logic signed [CTRL_W-1:0] w_ctrl_nx;
   logic signed [CTRL_W-1:0] w_ctrl_hold;

   always_comb begin
      w_p         = 64'(r_err1) >>> r_gain1.kp_sh;
      w_i_inc     = 64'(r_err1) >>> r_gain1.ki_sh;
      w_integ_nx  = ACC_W'(sat_add(64'(r_integ), w_i_inc, ACC_W));
      w_ctrl_nx   = CTRL_W'(sat_add(64'(w_integ_nx), w_p, CTRL_W));
      w_ctrl_hold = CTRL_W'(sat_add(64'(r_integ), 64'sd0, CTRL_W));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err1     <= '0;
         r_val1     <= 1'b0;
         r_gain1    <= '0;
         r_hold_d   <= 1'b0;
         r_integ    <= '0;
         r_ctrl     <= '0;
         r_ctrl_val <= 1'b0;
      end else begin
         // A clear squashes the sample in flight so it never lands after IDLE entry.
         r_err1     <= err;
         r_gain1    <= gains;
         r_val1     <= val && !clear;
         r_hold_d   <= hold;
         r_ctrl_val <= 1'b0;
         if (clear) begin
            r_integ    <= '0;
            r_ctrl     <= '0;
            r_ctrl_val <= (r_ctrl != '0);
         end else if (hold) begin
            if (!r_hold_d) begin
               r_ctrl     <= w_ctrl_hold;
               r_ctrl_val <= 1'b1;
            end
         end else if (r_val1) begin
            r_integ    <= w_integ_nx;
            r_ctrl     <= w_ctrl_nx;
            r_ctrl_val <= 1'b1;
         end
      end
   end

   assign ctrl     = r_ctrl;
   assign ctrl_val = r_ctrl_val;

endmodule
`default_nettype wire

// File: rtl/timing_loop_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : timing_loop_ctrl
// Desc     : Symbol-timing loop sequencer: state machine, lock detector, PI core
// Revision : 1.0 - initial release
// ============================================================================
module timing_loop_ctrl
   import timing_loop_pkg::*;
#(
   parameter int CTRL_W    = 18,
   parameter int ERR_W     = 16,
   parameter int ACC_W     = 24,
   parameter int KP_ACQ_SH = 2,
   parameter int KI_ACQ_SH = 6,
   parameter int KP_TRK_SH = 4,
   parameter int KI_TRK_SH = 10,
   parameter int ACQ_SYMS  = 256,
   parameter int LOCK_THR  = 1024,
   parameter int LOCK_SYMS = 64,
   parameter int LOSS_SYMS = 512
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable_i,
   input  logic              carrier_det_i,
   input  logic [ERR_W-1:0]  ted_err_i,
   input  logic              ted_val_i,
   input  logic              sym_valid_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic              ctrl_val_o,
   output logic [1:0]        state_o,
   output logic              locked_o
);

   localparam int        c_acq_cw  = $clog2(ACQ_SYMS);
   localparam int        c_lock_cw = $clog2(LOCK_SYMS + 1);
   localparam int        c_loss_cw = $clog2(LOSS_SYMS);
   localparam gain_set_t c_gain_acq = '{kp_sh: 5'(KP_ACQ_SH), ki_sh: 5'(KI_ACQ_SH)};
   localparam gain_set_t c_gain_trk = '{kp_sh: 5'(KP_TRK_SH), ki_sh: 5'(KI_TRK_SH)};

   loop_state_t            r_state;
   logic [c_acq_cw-1:0]    r_acq_cnt;
   logic [c_lock_cw-1:0]   r_lock_cnt;
   logic [c_loss_cw-1:0]   r_loss_cnt;
   logic                   r_locked;

   logic signed [ERR_W-1:0] w_err;
   logic [ERR_W-1:0]        w_abs_err;
   logic [c_lock_cw-1:0]    w_lock_nx;
   logic                    w_acq_done;
   logic                    w_loss_done;
   logic                    w_accept;
   logic                    w_clear;
   gain_set_t               w_gain;

   assign w_err       = ted_err_i;
   assign w_abs_err   = ERR_W'(abs_sat(64'(w_err), ERR_W));
   assign w_lock_nx   = (w_abs_err >= ERR_W'(LOCK_THR))           ? '0 :
                        (r_lock_cnt == c_lock_cw'(LOCK_SYMS))     ? r_lock_cnt :
                                                                    r_lock_cnt + 1'b1;
   assign w_acq_done  = (r_acq_cnt == c_acq_cw'(ACQ_SYMS - 1));
   assign w_loss_done = (r_loss_cnt == c_loss_cw'(LOSS_SYMS - 1));

   // Gains follow the registered state, so a sample on a transition cycle keeps the old gains.
   assign w_accept = ted_val_i && (r_state == ST_ACQ || r_state == ST_TRACK);
   assign w_gain   = (r_state == ST_TRACK) ? c_gain_trk : c_gain_acq;
   assign w_clear  = !enable_i || (r_state == ST_IDLE)
                   || (r_state == ST_ACQ && !carrier_det_i)
                   || (r_state == ST_HOLD && !carrier_det_i && sym_valid_i && w_loss_done);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_acq_cnt  <= '0;
         r_lock_cnt <= '0;
         r_loss_cnt <= '0;
         r_locked   <= 1'b0;
      end else if (!enable_i) begin
         r_state    <= ST_IDLE;
         r_acq_cnt  <= '0;
         r_lock_cnt <= '0;
         r_loss_cnt <= '0;
         r_locked   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (carrier_det_i)
                  r_state <= ST_ACQ;
            end
            ST_ACQ: begin
               if (!carrier_det_i) begin
                  r_state   <= ST_IDLE;
                  r_acq_cnt <= '0;
               end else if (ted_val_i) begin
                  if (w_acq_done) begin
                     r_state   <= ST_TRACK;
                     r_acq_cnt <= '0;
                  end else begin
                     r_acq_cnt <= r_acq_cnt + 1'b1;
                  end
               end
            end
            ST_TRACK: begin
               if (ted_val_i) begin
                  r_lock_cnt <= w_lock_nx;
                  r_locked   <= (w_lock_nx == c_lock_cw'(LOCK_SYMS));
               end
               if (!carrier_det_i) begin
                  r_state    <= ST_HOLD;
                  r_loss_cnt <= '0;
               end
            end
            ST_HOLD: begin
               if (carrier_det_i) begin
                  r_state    <= ST_TRACK;
                  r_loss_cnt <= '0;
                  r_lock_cnt <= '0;
                  r_locked   <= 1'b0;
               end else if (sym_valid_i) begin
                  if (w_loss_done) begin
                     r_state    <= ST_IDLE;
                     r_loss_cnt <= '0;
                     r_lock_cnt <= '0;
                     r_locked   <= 1'b0;
                  end else begin
                     r_loss_cnt <= r_loss_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   loop_pi_core #(
      .ERR_W  (ERR_W),
      .ACC_W  (ACC_W),
      .CTRL_W (CTRL_W)
   ) u_pi_core (
      .clk      (clk),
      .reset_n  (reset_n),
      .err      (ted_err_i),
      .val      (w_accept),
      .gains    (w_gain),
      .hold     (r_state == ST_HOLD),
      .clear    (w_clear),
      .ctrl     (ctrl_o),
      .ctrl_val (ctrl_val_o)
   );

   assign state_o  = r_state;
   assign locked_o = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_timing_loop_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_timing_loop_ctrl
// Desc     : Scoreboard bench for timing_loop_ctrl against an arithmetic loop model
// Revision : 1.0 - initial release
// ============================================================================
module tb_timing_loop_ctrl;

   localparam int CTRL_W = 18, ERR_W = 16, ACC_W = 24;
   localparam int KP_ACQ = 2, KI_ACQ = 6, KP_TRK = 4, KI_TRK = 10;
   localparam int ACQ_SYMS = 256, LOCK_THR = 1024, LOCK_SYMS = 64, LOSS_SYMS = 512;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              enable_i = 1'b0;
   logic              carrier_det_i = 1'b0;
   logic [ERR_W-1:0]  ted_err_i = '0;
   logic              ted_val_i = 1'b0;
   logic              sym_valid_i = 1'b0;
   logic [CTRL_W-1:0] ctrl_o;
   logic              ctrl_val_o;
   logic [1:0]        state_o;
   logic              locked_o;

   timing_loop_ctrl #(
      .CTRL_W(CTRL_W), .ERR_W(ERR_W), .ACC_W(ACC_W),
      .KP_ACQ_SH(KP_ACQ), .KI_ACQ_SH(KI_ACQ), .KP_TRK_SH(KP_TRK), .KI_TRK_SH(KI_TRK),
      .ACQ_SYMS(ACQ_SYMS), .LOCK_THR(LOCK_THR), .LOCK_SYMS(LOCK_SYMS), .LOSS_SYMS(LOSS_SYMS)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .carrier_det_i(carrier_det_i),
      .ted_err_i(ted_err_i), .ted_val_i(ted_val_i), .sym_valid_i(sym_valid_i),
      .ctrl_o(ctrl_o), .ctrl_val_o(ctrl_val_o), .state_o(state_o), .locked_o(locked_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { longint ctrl; int cyc; } exp_t;
   exp_t sb[$];
   int n_cmp = 0;
   int n_fail = 0;

   // Loop model: 0 idle, 1 acquire, 2 track, 3 hold
   int     m_state = 0;
   longint m_integ = 0;
   longint m_ctrl  = 0;
   int     m_acq = 0, m_lock = 0, m_loss = 0;
   bit     m_locked = 1'b0;

   function automatic longint sat(input longint x, input int w);
      longint lim;
      lim = (longint'(1) << (w - 1)) - 1;
      if (x > lim) return lim;
      if (x < -lim) return -lim;
      return x;
   endfunction

   // Floor division by 2^sh, i.e. an arithmetic right shift.
   function automatic longint fdiv(input longint x, input int sh);
      longint d;
      d = longint'(1) << sh;
      if (x >= 0) return x / d;
      return -((-x + d - 1) / d);
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic model_idle();
      m_state = 0; m_integ = 0; m_ctrl = 0;
      m_acq = 0; m_lock = 0; m_loss = 0; m_locked = 1'b0;
   endtask

   task automatic send(input longint e);
      int     kp, ki;
      longint a;
      if (m_state == 1 || m_state == 2) begin
         kp = (m_state == 1) ? KP_ACQ : KP_TRK;
         ki = (m_state == 1) ? KI_ACQ : KI_TRK;
         m_integ = sat(m_integ + fdiv(e, ki), ACC_W);
         m_ctrl  = sat(m_integ + fdiv(e, kp), CTRL_W);
         sb.push_back('{ctrl: m_ctrl, cyc: cyc + 2});
         if (m_state == 2) begin
            a = (e < 0) ? -e : e;
            if (a > 32767) a = 32767;
            m_lock   = (a < LOCK_THR) ? ((m_lock < LOCK_SYMS) ? m_lock + 1 : LOCK_SYMS) : 0;
            m_locked = (m_lock == LOCK_SYMS);
         end else begin
            m_acq++;
            if (m_acq == ACQ_SYMS) begin
               m_state = 2;
               m_acq   = 0;
            end
         end
      end
      ted_err_i = ERR_W'(e);
      ted_val_i = 1'b1;
      tick();
      ted_val_i = 1'b0;
      check("state_o", longint'(state_o), m_state);
      check("locked_o", longint'(locked_o), longint'(m_locked));
   endtask

   function automatic longint rnd_err(input int span);
      return longint'($urandom_range(0, 2 * span)) - span;
   endfunction

   task automatic go_acq();
      enable_i = 1'b1;
      carrier_det_i = 1'b1;
      tick();
      m_state = 1;
      check("state_enter_acq", longint'(state_o), 1);
   endtask

   task automatic drop_enable(input bit with_sample, input longint e);
      idle(3);
      if (m_ctrl != 0) sb.push_back('{ctrl: 0, cyc: cyc + 1});
      model_idle();
      enable_i  = 1'b0;
      ted_err_i = ERR_W'(e);
      ted_val_i = with_sample;
      tick();
      ted_val_i = 1'b0;
      check("state_after_disable", longint'(state_o), 0);
   endtask

   task automatic carrier_drop();
      carrier_det_i = 1'b0;
      m_state = 3;
      m_loss  = 0;
      m_ctrl  = sat(m_integ, CTRL_W);
      sb.push_back('{ctrl: m_ctrl, cyc: cyc + 2});
      tick();
      check("state_enter_hold", longint'(state_o), 3);
   endtask

   task automatic carrier_up();
      carrier_det_i = 1'b1;
      m_state = 2; m_loss = 0; m_lock = 0; m_locked = 1'b0;
      tick();
      check("state_hold_to_track", longint'(state_o), 2);
   endtask

   task automatic sym_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         if (m_state == 3) begin
            if (m_loss == LOSS_SYMS - 1) begin
               if (m_ctrl != 0) sb.push_back('{ctrl: 0, cyc: cyc + 1});
               model_idle();
            end else begin
               m_loss++;
            end
         end
         sym_valid_i = 1'b1;
         tick();
         sym_valid_i = 1'b0;
         idle(int'($urandom_range(0, 2)));
      end
      check("state_after_sym", longint'(state_o), m_state);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL missed_pulse: no ctrl_val_o pulse by cycle %0d, expected ctrl_o=%0d at cycle %0d",
                     cyc, e.ctrl, e.cyc);
         end
         if (reset_n && ctrl_val_o) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_pulse: ctrl_o=%0d at cycle %0d, expected no pulse",
                        $signed(ctrl_o), cyc);
            end else begin
               e = sb.pop_front();
               check("pulse_ctrl_o", longint'($signed(ctrl_o)), e.ctrl);
               check("pulse_cycle", cyc, e.cyc);
            end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      fork
         monitor();
      join_none

      idle(3);
      check("reset_ctrl_o", longint'(ctrl_o), 0);
      check("reset_ctrl_val", longint'(ctrl_val_o), 0);
      check("reset_state", longint'(state_o), 0);
      check("reset_locked", longint'(locked_o), 0);
      reset_n = 1'b1;
      tick();

      // Asynchronous reset in the middle of acquisition with integrator at 5000
      go_acq();
      repeat (78) send(4096);
      send(512);
      idle(4);
      check("queue_drained_pre_reset", sb.size(), 0);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_ctrl_o", longint'(ctrl_o), 0);
      check("async_rst_ctrl_val", longint'(ctrl_val_o), 0);
      check("async_rst_state", longint'(state_o), 0);
      check("async_rst_locked", longint'(locked_o), 0);
      model_idle();
      enable_i = 1'b0;
      carrier_det_i = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();

      // Acquisition with constant error, then first tracking update
      go_acq();
      send(4096);
      tick();
      check("first_acq_ctrl", longint'($signed(ctrl_o)), 1088);
      check("first_acq_val", longint'(ctrl_val_o), 1);
      repeat (ACQ_SYMS - 1) send(4096);
      send(4096);

      // Lock detector
      for (int i = 0; i < LOCK_SYMS; i++) begin
         send((i % 2 == 0) ? 512 : -512);
         idle(int'($urandom_range(0, 2)));
      end
      check("locked_after_64", longint'(locked_o), 1);
      send(2000);
      check("unlocked_after_big_err", longint'(locked_o), 0);
      repeat (40) send(rnd_err(1100));
      send(-32768);
      repeat (20) send(rnd_err(900));

      // Output saturation in both directions
      drop_enable(1'b0, 0);
      go_acq();
      repeat (2000) send(32767);
      idle(3);
      check("sat_pos_ctrl", longint'($signed(ctrl_o)), 131071);
      drop_enable(1'b0, 0);
      go_acq();
      repeat (2000) send(-32768);
      idle(3);
      check("sat_neg_ctrl", longint'($signed(ctrl_o)), -131071);

      // Carrier loss: hold, recover, then time out to idle
      drop_enable(1'b0, 0);
      go_acq();
      repeat (46) send(4096);
      send(3584);
      repeat (ACQ_SYMS - 47) send(0);
      idle(3);
      carrier_drop();
      idle(3);
      check("hold_ctrl_3000", longint'($signed(ctrl_o)), 3000);
      repeat (5) send(rnd_err(20000));
      sym_pulses(LOSS_SYMS - 1);
      check("hold_after_511", longint'(state_o), 3);
      carrier_up();
      carrier_drop();
      idle(3);
      sym_pulses(LOSS_SYMS);
      idle(2);
      check("idle_after_512", longint'(state_o), 0);
      check("ctrl_zero_after_loss", longint'($signed(ctrl_o)), 0);

      // Enable dropped on the same cycle as a tracking sample
      go_acq();
      repeat (ACQ_SYMS) send(rnd_err(2000));
      repeat (10) send(rnd_err(3000));
      drop_enable(1'b1, 20000);
      idle(3);
      check("disable_ctrl_zero", longint'($signed(ctrl_o)), 0);
      check("disable_state_idle", longint'(state_o), 0);

      idle(5);
      check("queue_empty_at_end", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/timing_loop_ctrl.md
Name: timing_loop_ctrl

Overview:
Sequences the symbol-timing recovery loop for the MSK receiver. It takes timing-error-detector (TED) samples and runs an acquire/track PI loop filter with gain scheduling. It drives the signed correction word and valid strobe into the Q5.27 phase accumulator. It also owns loop state (idle, acquire, track, hold), the lock detector, and the free-run hold on carrier loss.

Parameters:
CTRL_W, 18, width of ctrl_o; LSB = 2^-12 symbol (accumulator correction format)
ERR_W, 16, width of signed TED error input
ACC_W, 24, integrator width; integrator LSB = ctrl_o LSB
KP_ACQ_SH, 2, proportional right-shift in ACQ
KI_ACQ_SH, 6, integral right-shift in ACQ
KP_TRK_SH, 4, proportional right-shift in TRACK
KI_TRK_SH, 10, integral right-shift in TRACK
ACQ_SYMS, 256, TED updates spent in ACQ before TRACK
LOCK_THR, 1024, |err| threshold for the lock count
LOCK_SYMS, 64, consecutive in-threshold updates to declare lock
LOSS_SYMS, 512, sym_valid_i pulses tolerated in HOLD before IDLE

Ports:
clk  in  1  system clock (200 MHz sample clock)
reset_n  in  1  asynchronous active-low reset
enable_i  in  1  loop enable (software)
carrier_det_i  in  1  energy/carrier detect, level
ted_err_i  in  ERR_W  signed timing error
ted_val_i  in  1  ted_err_i valid, at most one per symbol
sym_valid_i  in  1  symbol strobe from phase accumulator
ctrl_o  out  CTRL_W  signed correction to phase accumulator
ctrl_val_o  out  1  1-cycle pulse when ctrl_o updates
state_o  out  2  0=IDLE 1=ACQ 2=TRACK 3=HOLD
locked_o  out  1  lock indication

Behaviour:
- Reset (async, any time): state IDLE, integrator 0, ctrl_o 0, ctrl_val_o 0, locked_o 0, all counters 0.
- enable_i=0 in any state -> IDLE on the next clk. Integrator and ctrl_o clear to 0. ctrl_val_o pulses once with 0 if ctrl_o was nonzero.
- IDLE: ted_val_i ignored. enable_i & carrier_det_i -> ACQ.
- ACQ: PI with ACQ shifts. acq_cnt increments per accepted ted_val_i. When acq_cnt reaches ACQ_SYMS-1 and ted_val_i is accepted -> TRACK. Integrator is retained (bumpless). carrier_det_i=0 -> IDLE.
- TRACK: PI with TRK shifts, plus the lock detector. carrier_det_i=0 -> HOLD.
- HOLD: ted_val_i ignored, integrator frozen, ctrl_o = sat(integrator) with no proportional term. A single ctrl_val_o pulse fires on entry. loss_cnt counts sym_valid_i.
  - carrier_det_i=1 -> TRACK; loss_cnt cleared, lock count cleared.
  - loss_cnt reaches LOSS_SYMS -> IDLE.
- Gain selection uses the registered state in the cycle ted_val_i is sampled. A sample arriving on a transition cycle uses the old state's gains.
- Pipeline: ted_val_i at cycle N -> error registered at N+1 -> ctrl_o updated and ctrl_val_o high at N+2. Fixed latency 2. Back-to-back ted_val_i (every cycle) must be sustained.
- Arithmetic:
  - p = err >>> KP_SH and i_inc = err >>> KI_SH (arithmetic shifts, sign-extended to ACC_W+1).
  - integ = sat_ACC(integ + i_inc), symmetric ±(2^(ACC_W-1)-1).
  - ctrl_o = sat_CTRL(integ + p), symmetric ±(2^(CTRL_W-1)-1). -2^(CTRL_W-1) is never output.
- Lock detector (TRACK only), per accepted ted_val_i:
  - |err| computed with -2^(ERR_W-1) mapped to 2^(ERR_W-1)-1.
  - |err| < LOCK_THR: lock_cnt++, saturating at LOCK_SYMS. Otherwise lock_cnt = 0 and locked_o drops in the same cycle lock_cnt clears.
  - locked_o=1 when lock_cnt == LOCK_SYMS.
  - HOLD keeps locked_o. IDLE or ACQ forces locked_o 0.
- ctrl_val_o never pulses in IDLE except the single clear pulse above.

Decomposition:
- Package timing_loop_pkg:
  - loop_state_t enum (IDLE, ACQ, TRACK, HOLD; 2-bit encoding matching state_o).
  - Saturating add function sat_add(a, b, width).
  - abs_sat function.
  - Gain-set struct {kp_sh, ki_sh}.
- One sub-module, loop_pi_core: 2-stage PI datapath.
  - Inputs: err, val, gain set, hold, clear.
  - Outputs: ctrl, ctrl_val.
- timing_loop_ctrl keeps the FSM, counters and lock detector.

Test Plan:
1. Reset mid-ACQ with integrator=5000: assert reset_n=0 asynchronously -> all outputs 0 before the next clk edge, state_o=0.
2. enable=1, carrier=1, constant err=+4096 x 256 updates:
   - ACQ: first ctrl_o=1024+64=1088 at N+2.
   - Update 256 moves state_o to 2.
   - Next update uses TRK shifts: integ increments by +4.
3. TRACK with err alternating ±512 for 64 updates -> locked_o rises on the 64th update's cycle. One err=2000 -> locked_o falls.
4. Saturation: err=+32767 every cycle for 2000 cycles in ACQ -> ctrl_o clips at 131071, never wraps negative. err=-32768 -> clips at -131071.
5. Carrier drop in TRACK with integ=3000:
   - state_o=3, ctrl_o=3000 with one ctrl_val_o pulse.
   - 511 sym_valid pulses then carrier=1 -> TRACK.
   - Repeat with 512 pulses -> IDLE, ctrl_o=0.
6. enable_i dropped in the same cycle as ted_val_i in TRACK -> IDLE next clk. The sample is not applied to the integrator after IDLE entry; ctrl_o ends at 0.
